// File: rtl/gate_stim_pkg.sv
// Shared types and default sizing for the gate stimulus sequencer.
// The sequencer replays timed {a,b,c,d} vectors into built_in_gates.
package gate_stim_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int HOLD_W = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/gate_stim_hold_cnt.sv
// Per-vector hold timer: loads a hold count (0 promoted to 1) and flags the
// final cycle of the current vector.
module gate_stim_hold_cnt
  import gate_stim_pkg::*;
#(
  parameter int HOLD_W = gate_stim_pkg::HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] hold,
  output logic              last_cycle
);

  localparam logic [HOLD_W-1:0] ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt;

  // cnt holds the cycles remaining for the current vector, including this one,
  // so a full-scale hold never needs an extra bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (hold == '0) ? ONE : hold;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign last_cycle = (cnt == ONE);

endmodule

// File: rtl/gate_stim_sequencer.sv
// Programmable vector table player driving the a,b,c,d inputs of
// built_in_gates; every output comes straight from a flop.
module gate_stim_sequencer
  import gate_stim_pkg::*;
#(
  parameter int DEPTH  = gate_stim_pkg::DEPTH,
  parameter int ADDR_W = gate_stim_pkg::ADDR_W,
  parameter int HOLD_W = gate_stim_pkg::HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_vec,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              vec_valid,
  output logic [ADDR_W-1:0] vec_idx,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  vec_t              vec_mem  [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];

  logic [ADDR_W-1:0] last_q, last_n;
  logic [ADDR_W-1:0] idx_n, tgt;
  vec_t              vec_q, vec_n;
  logic              play, load, last_cycle, done_n;

  // NOTE: the table is cleared by reset because reset must leave every entry
  // at vec 0 / hold 0; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vec_mem[i]  <= '0;
        hold_mem[i] <= '0;
      end
    end else if (wr_en && state == IDLE) begin
      vec_mem[wr_addr]  <= vec_t'(wr_vec);
      hold_mem[wr_addr] <= wr_hold;
    end
  end

  gate_stim_hold_cnt #(.HOLD_W(HOLD_W)) u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hold       (hold_mem[tgt]),
    .last_cycle (last_cycle)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    last_n  = last_q;
    tgt     = vec_idx;
    play    = 1'b0;
    load    = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // abort has priority over start.
        if (start && !abort) begin
          state_n = RUN;
          last_n  = last_idx;
          tgt     = '0;
          play    = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!last_cycle) begin
          play = 1'b1;
        end else if (vec_idx != last_q) begin
          tgt  = vec_idx + 1'b1;
          play = 1'b1;
          load = 1'b1;
        end else if (loop_en) begin
          tgt  = '0;
          play = 1'b1;
          load = 1'b1;
        end else begin
          state_n = FIN;
          done_n  = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    idx_n = play ? tgt : '0;
    vec_n = play ? vec_mem[tgt] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= '0;
      vec_q     <= '0;
      vec_idx   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      last_q    <= last_n;
      vec_q     <= vec_n;
      vec_idx   <= idx_n;
      vec_valid <= play;
      busy      <= play;
      done      <= done_n;
    end
  end

  assign a = vec_q.a;
  assign b = vec_q.b;
  assign c = vec_q.c;
  assign d = vec_q.d;

endmodule

// File: tb/tb_gate_stim_sequencer.sv
// Scoreboard bench for gate_stim_sequencer: expected per-cycle outputs are
// queued from a table model when playback is started and popped each cycle.
module tb_gate_stim_sequencer;

  logic       clk, rst_n;
  logic       wr_en, loop_en, start, abort;
  logic [2:0] wr_addr, last_idx;
  logic [3:0] wr_vec;
  logic [7:0] wr_hold;
  logic       a, b, c, d, vec_valid, busy, done;
  logic [2:0] vec_idx;

  gate_stim_sequencer #(.DEPTH(8), .ADDR_W(3), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_vec    (wr_vec),
    .wr_hold   (wr_hold),
    .last_idx  (last_idx),
    .loop_en   (loop_en),
    .start     (start),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .vec_valid (vec_valid),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] abcd;
    logic       valid;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t       exp_q[$];
  logic [3:0] m_vec  [8];
  logic [7:0] m_hold [8];
  int         checks   = 0;
  int         failures = 0;
  string      cur_tag  = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (abcd,valid,idx,busy,done)", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    return {a, b, c, d, vec_valid, vec_idx, busy, done};
  endfunction

  function automatic void push_obs(logic [3:0] v, logic val, logic [2:0] i, logic bz, logic dn);
    exp_q.push_back({v, val, i, bz, dn});
  endfunction

  function automatic void push_entry(int k);
    int n;
    n = (m_hold[k] == 8'd0) ? 1 : int'(m_hold[k]);
    repeat (n) push_obs(m_vec[k], 1'b1, 3'(k), 1'b1, 1'b0);
  endfunction

  function automatic void push_idle(int n);
    repeat (n) push_obs(4'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction

  function automatic void push_fin();
    push_obs(4'b0, 1'b0, 3'd0, 1'b0, 1'b1);
  endfunction

  // One clock: sample on the falling edge and compare against the scoreboard.
  task automatic cyc();
    obs_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(cur_tag, {20'b0, observe()}, {20'b0, e});
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) cyc();
  endtask

  task automatic write_entry(input int addr, input logic [3:0] v, input logic [7:0] h);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_vec  = v;
    wr_hold = h;
    cyc();
    wr_en   = 1'b0;
    m_vec[addr]  = v;
    m_hold[addr] = h;
  endtask

  // Starts a non-looping playback and queues its full expected trace.
  task automatic start_play(input int last);
    last_idx = 3'(last);
    loop_en  = 1'b0;
    start    = 1'b1;
    for (int k = 0; k <= last; k++) push_entry(k);
    push_fin();
    push_idle(2);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_vec = '0; wr_hold = '0;
    last_idx = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_vec[i]  = '0;
      m_hold[i] = '0;
    end

    // 1: reset held three cycles, then idle with no start.
    push_idle(3);
    repeat (3) cyc();
    rst_n   = 1'b1;
    cur_tag = "idle";
    push_idle(10);
    drain();

    // 2: full playback of five entries.
    cur_tag = "play5";
    write_entry(0, 4'b1010, 8'd1);
    write_entry(1, 4'b0101, 8'd2);
    write_entry(2, 4'b0010, 8'd1);
    write_entry(3, 4'b1111, 8'd1);
    write_entry(4, 4'b0000, 8'd5);
    start_play(4);
    drain();

    // 3: two-entry loop, then loop_en dropped during a 1100 cycle.
    cur_tag = "loop";
    write_entry(0, 4'b1100, 8'd1);
    write_entry(1, 4'b0011, 8'd1);
    last_idx = 3'd1;
    loop_en  = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 21; i++) push_entry(i % 2);
    push_entry(1);
    push_fin();
    push_idle(1);
    cyc();
    start = 1'b0;
    repeat (20) cyc();
    loop_en = 1'b0;
    drain();

    // 4: abort on the final cycle of last_idx, then start with abort in IDLE.
    cur_tag  = "abort_end";
    last_idx = 3'd1;
    start    = 1'b1;
    push_entry(0);
    push_entry(1);
    push_idle(3);
    cyc();
    start = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    drain();
    cur_tag = "abort_start";
    start   = 1'b1;
    abort   = 1'b1;
    push_idle(3);
    cyc();
    start = 1'b0;
    abort = 1'b0;
    drain();

    // 5: all eight entries, hold 0 and hold 255 included.
    cur_tag = "play8";
    for (int k = 0; k < 8; k++)
      write_entry(k, 4'((k * 3 + 1) % 16), (k == 0) ? 8'd0 : (k == 1) ? 8'd255 : 8'(k % 3));
    start_play(7);
    drain();

    // 5b: a write attempted during playback must not reach the table.
    cur_tag = "wr_in_run";
    start_play(2);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_vec  = 4'b1111;
    wr_hold = 8'd3;
    cyc();
    wr_en = 1'b0;
    drain();
    cur_tag = "replay";
    start_play(2);
    drain();

    // 6: synchronous reset while entry 2 is playing.
    cur_tag = "mid_reset";
    write_entry(0, 4'b1010, 8'd1);
    write_entry(1, 4'b0101, 8'd2);
    write_entry(2, 4'b0010, 8'd1);
    write_entry(3, 4'b1111, 8'd1);
    write_entry(4, 4'b0000, 8'd5);
    last_idx = 3'd4;
    start    = 1'b1;
    push_entry(0);
    push_entry(1);
    push_entry(2);
    push_idle(3);
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drain();
    for (int i = 0; i < 8; i++) begin
      m_vec[i]  = '0;
      m_hold[i] = '0;
    end
    cur_tag = "cleared";
    start_play(2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
